decode_rename_buffer: RTL and testbench
=======================================

Name: decode_rename_buffer

Overview:
- Dual-decoder to rename pipeline stage.
- Each of two decoders emits up to two micro-ops per cycle (uop1 is used for split instructions such as HI/LO writes), so up to 4 uops arrive per cycle.
- The block compacts them in program order, buffers any excess, and presents at most 2 uops per cycle to rename through registered outputs.
- Honours the stage controls pause and flush, and raises pause_req to stall fetch/decode when buffer space runs low.

Parameters:
- UOP_W, 128, width of one opaque uop payload (not interpreted).
- DEPTH, 8, overflow FIFO entries; must be >= 4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- flush  in  1  discard all buffered/incoming uops (pipeline redirect)
- pause  in  1  downstream stall; output registers hold
- pause_req  out  1  request upstream stall; inputs ignored while high
- d0_uop0_valid / d0_uop0  in  1 / UOP_W  decoder 0, first uop
- d0_uop1_valid / d0_uop1  in  1 / UOP_W  decoder 0, second uop
- d1_uop0_valid / d1_uop0  in  1 / UOP_W  decoder 1, first uop
- d1_uop1_valid / d1_uop1  in  1 / UOP_W  decoder 1, second uop
- out_uop0_valid / out_uop0  out  1 / UOP_W  older uop to rename
- out_uop1_valid / out_uop1  out  1 / UOP_W  younger uop to rename

Behaviour:
- **Program order** is d0_uop0, d0_uop1, d1_uop0, d1_uop1.
  - Invalid slots are squeezed out (compaction).
  - Any valid/invalid combination is legal.
- **State**:
  - Circular FIFO of DEPTH entries with head, tail and count (0..DEPTH).
  - Two output registers with valid bits.
- **pause_req**: combinational; equals (count > DEPTH-4). It guarantees room for 4 uops while stalled.
- **Accept**: inputs are taken at a rising edge only when rst=1, flush=0 and pause_req=0; otherwise all inputs are ignored.
- **Latency**: 1 cycle, with bypass.
  - Form a combined ordered list: FIFO contents (head first), then accepted compacted inputs.
  - When pause=0, the first two list entries load into out_uop0 and out_uop1; the rest are written to the FIFO tail in order.
  - One available uop: goes to out_uop0, with out_uop1_valid=0.
  - No uops available: both valids are 0.
- **pause=1**:
  - Output registers hold value and valid.
  - Accepted inputs are all enqueued to the FIFO; nothing dequeues.
- **Slot rule**: out_uop1_valid=1 implies out_uop0_valid=1.
- **Payload of invalid slots**: drive all-zero payload whenever the slot's valid is 0.
- **FIFO wrap**: head and tail wrap modulo DEPTH; count never exceeds DEPTH (guaranteed by the pause_req rule).
- **Reset (rst=0 at edge)**: count=0, head=tail=0, both out valids=0, payloads=0, pause_req=0.
- **Flush (flush=1 at edge, rst=1)**: same effect as reset on FIFO and outputs. Flush has priority over pause and over input acceptance.
- **Simultaneous pause and flush**: flush wins.
- **Reset or flush mid-stall**: all buffered uops are lost; pause_req drops in the same cycle count reaches 0 (the following cycle).

Test Plan:
- **Reset**: rst=0 for 2 cycles, then rst=1 with no inputs -> both out valids 0, pause_req 0.
- **Single-issue ordering**:
  - Cycle N: d0_uop0=A, d1_uop0=B valid (uop1s invalid) -> at N+1 out0=A, out1=B, FIFO empty.
  - Cycle N: only d1_uop1=C valid -> out0=C, out1_valid=0.
- **Overflow with DEPTH=8**:
  - Drive 4 valid uops (U0..U3, U4..U7, ...) every cycle, pause=0.
  - The 2 extra uops per cycle accumulate in the FIFO: count 2, 4, 6; pause_req rises when count=6.
  - Inputs are ignored while pause_req=1.
  - Outputs continue in strict order U0,U1,U2,... with no loss or duplication until the FIFO drains and pause_req falls (count <= 4).
- **Pause hold**:
  - pause=1 for 3 cycles while 2 uops/cycle arrive -> outputs frozen; count rises 2, 4, 6; pause_req=1.
  - pause=0 -> the FIFO drains 2 per cycle in order.
- **Flush**:
  - With count=5 and valid outputs, assert flush together with pause=1 and 4 valid inputs -> next cycle count=0, both valids 0, pause_req 0, none of the 4 inputs ever appear.
- **Wrap-around**: stream more than 3×DEPTH uops through with random pause and random valid patterns -> output sequence equals compacted input sequence (scoreboard model); out_uop1_valid is never 1 while out_uop0_valid is 0.

Source files
------------

// File: rtl/decode_rename_buffer_if.sv
// Decoder-to-rename stage bundle: four decoder uop slots, stage controls and
// the registered output pair presented to rename.
//
// Handshake: a decoder slot transfers when its *_valid is high at a rising
// clock edge while flush is low and pause_req is low. There is no per-slot
// ready; pause_req is the one back-pressure signal covering all four input
// slots. On the output side, rename consumes out_uop0/out_uop1 on every edge
// where pause is low. While pause is high the output pair holds.
interface decode_rename_buffer_if #(
    parameter int UOP_W = 128
);
    logic             flush;
    logic             pause;
    logic             pause_req;
    logic             d0_uop0_valid;
    logic [UOP_W-1:0] d0_uop0;
    logic             d0_uop1_valid;
    logic [UOP_W-1:0] d0_uop1;
    logic             d1_uop0_valid;
    logic [UOP_W-1:0] d1_uop0;
    logic             d1_uop1_valid;
    logic [UOP_W-1:0] d1_uop1;
    logic             out_uop0_valid;
    logic [UOP_W-1:0] out_uop0;
    logic             out_uop1_valid;
    logic [UOP_W-1:0] out_uop1;

    modport master (
        output flush, pause,
        output d0_uop0_valid, d0_uop0, d0_uop1_valid, d0_uop1,
        output d1_uop0_valid, d1_uop0, d1_uop1_valid, d1_uop1,
        input  pause_req,
        input  out_uop0_valid, out_uop0, out_uop1_valid, out_uop1
    );

    modport slave (
        input  flush, pause,
        input  d0_uop0_valid, d0_uop0, d0_uop1_valid, d0_uop1,
        input  d1_uop0_valid, d1_uop0, d1_uop1_valid, d1_uop1,
        output pause_req,
        output out_uop0_valid, out_uop0, out_uop1_valid, out_uop1
    );
endinterface

// File: rtl/decode_rename_buffer.sv
// Decode-to-rename buffer: compacts up to four decoder uops per cycle into
// program order, hands the two oldest to rename through registered outputs,
// and parks the rest in a circular FIFO. pause_req stalls decode whenever
// fewer than four FIFO entries are free.
module decode_rename_buffer #(
    parameter int UOP_W = 128,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    decode_rename_buffer_if.slave   io
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [UOP_W-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;

    logic             out0_v;
    logic             out1_v;
    logic [UOP_W-1:0] out0_d;
    logic [UOP_W-1:0] out1_d;

    logic [3:0]       in_v;
    logic [UOP_W-1:0] in_d [4];
    logic             accept;
    logic [UOP_W-1:0] cmp_d [4];
    logic [2:0]       n_in;

    logic             nxt0_v;
    logic             nxt1_v;
    logic [UOP_W-1:0] nxt0_d;
    logic [UOP_W-1:0] nxt1_d;
    logic [2:0]       n_deq;
    logic [2:0]       n_take;
    logic [2:0]       n_enq;

    // Pointer advance with wrap; k never exceeds 4 and DEPTH >= 4, so one subtraction suffices.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [2:0] k);
        int s;
        s = int'(p) + int'(k);
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    assign in_v    = {io.d1_uop1_valid, io.d1_uop0_valid, io.d0_uop1_valid, io.d0_uop0_valid};
    assign in_d[0] = io.d0_uop0;
    assign in_d[1] = io.d0_uop1;
    assign in_d[2] = io.d1_uop0;
    assign in_d[3] = io.d1_uop1;

    assign io.pause_req = (int'(count) > DEPTH - 4);
    assign accept       = !io.flush && !io.pause_req;

    // Squeeze invalid slots out of the four decoder slots, keeping program order.
    always_comb begin
        n_in = '0;
        for (int i = 0; i < 4; i++) cmp_d[i] = '0;
        for (int i = 0; i < 4; i++) begin
            if (accept && in_v[i]) begin
                cmp_d[n_in[1:0]] = in_d[i];
                n_in             = n_in + 3'd1;
            end
        end
    end

    // Pick the two oldest of {FIFO head first, then compacted inputs} for rename.
    always_comb begin
        nxt0_v = 1'b0;
        nxt1_v = 1'b0;
        nxt0_d = '0;
        nxt1_d = '0;
        n_deq  = '0;
        n_take = '0;
        if (!io.pause) begin
            if (count != '0) begin
                nxt0_v = 1'b1;
                nxt0_d = mem[head];
                n_deq  = 3'd1;
            end else if (n_in != '0) begin
                nxt0_v = 1'b1;
                nxt0_d = cmp_d[0];
                n_take = 3'd1;
            end
            if (count > CW'(1)) begin
                nxt1_v = 1'b1;
                nxt1_d = mem[ptr_add(head, 3'd1)];
                n_deq  = 3'd2;
            end else if (n_in > n_take) begin
                nxt1_v = 1'b1;
                nxt1_d = cmp_d[n_take[1:0]];
                n_take = n_take + 3'd1;
            end
        end
    end

    assign n_enq = n_in - n_take;

    // Append every compacted input not sent straight to rename at the FIFO tail.
    always_ff @(posedge clk) begin
        if (rst && !io.flush) begin
            for (int e = 0; e < 4; e++) begin
                if (3'(e) < n_enq) mem[ptr_add(tail, 3'(e))] <= cmp_d[2'(n_take + 3'(e))];
            end
        end
    end

    // Pointers, occupancy and output registers; reset and flush both empty the stage.
    always_ff @(posedge clk) begin
        if (!rst || io.flush) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            out0_v <= 1'b0;
            out1_v <= 1'b0;
            out0_d <= '0;
            out1_d <= '0;
        end else begin
            head  <= ptr_add(head, n_deq);
            tail  <= ptr_add(tail, n_enq);
            count <= count - CW'(n_deq) + CW'(n_enq);
            if (!io.pause) begin
                out0_v <= nxt0_v;
                out1_v <= nxt1_v;
                out0_d <= nxt0_d;
                out1_d <= nxt1_d;
            end
        end
    end

    assign io.out_uop0_valid = out0_v;
    assign io.out_uop1_valid = out1_v;
    assign io.out_uop0       = out0_d;
    assign io.out_uop1       = out1_d;
endmodule

// File: tb/tb_decode_rename_buffer.sv
// Bench for decode_rename_buffer: a queue-level model of the stage checked
// every cycle, plus directed checks with hand-computed values.
module tb_decode_rename_buffer;
    localparam int UOP_W = 128;
    localparam int DEPTH = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    decode_rename_buffer_if #(.UOP_W(UOP_W)) bus ();

    decode_rename_buffer #(.UOP_W(UOP_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [UOP_W-1:0] act, input logic [UOP_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [3:0] v, input logic [UOP_W-1:0] a, input logic [UOP_W-1:0] b,
                         input logic [UOP_W-1:0] c, input logic [UOP_W-1:0] d,
                         input logic p, input logic f);
        bus.d0_uop0_valid = v[0];
        bus.d0_uop0       = a;
        bus.d0_uop1_valid = v[1];
        bus.d0_uop1       = b;
        bus.d1_uop0_valid = v[2];
        bus.d1_uop0       = c;
        bus.d1_uop1_valid = v[3];
        bus.d1_uop1       = d;
        bus.pause         = p;
        bus.flush         = f;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(4'b0000, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    // ---------------- behavioural model / scoreboard ----------------
    // exp_q holds the uops the stage must still owe rename, oldest first.
    logic [UOP_W-1:0] exp_q[$];
    logic [UOP_W-1:0] tmp_q[$];
    logic             m_v0 = 1'b0;
    logic             m_v1 = 1'b0;
    logic [UOP_W-1:0] m_d0 = '0;
    logic [UOP_W-1:0] m_d1 = '0;

    always @(posedge clk) begin
        if (!rst || bus.flush) begin
            exp_q.delete();
            m_v0 = 1'b0; m_v1 = 1'b0; m_d0 = '0; m_d1 = '0;
        end else begin
            tmp_q = exp_q;
            if (exp_q.size() <= DEPTH - 4) begin
                if (bus.d0_uop0_valid) tmp_q.push_back(bus.d0_uop0);
                if (bus.d0_uop1_valid) tmp_q.push_back(bus.d0_uop1);
                if (bus.d1_uop0_valid) tmp_q.push_back(bus.d1_uop0);
                if (bus.d1_uop1_valid) tmp_q.push_back(bus.d1_uop1);
            end
            if (!bus.pause) begin
                m_v0 = 1'b0; m_v1 = 1'b0; m_d0 = '0; m_d1 = '0;
                if (tmp_q.size() > 0) begin m_v0 = 1'b1; m_d0 = tmp_q.pop_front(); end
                if (tmp_q.size() > 0) begin m_v1 = 1'b1; m_d1 = tmp_q.pop_front(); end
            end
            exp_q = tmp_q;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("out0_valid", bus.out_uop0_valid, m_v0);
            chk("out0_data", bus.out_uop0, m_d0);
            chk("out1_valid", bus.out_uop1_valid, m_v1);
            chk("out1_data", bus.out_uop1, m_d1);
            chk("pause_req", bus.pause_req, (exp_q.size() > DEPTH - 4));
            chk("count", dut.count, exp_q.size());
            chk("slot_rule", bus.out_uop1_valid & ~bus.out_uop0_valid, 1'b0);
        end
    end

    function automatic logic [UOP_W-1:0] tok(input logic [UOP_W-1:0] base, input int k);
        return base + UOP_W'(k);
    endfunction

    // ---------------- directed + random stimulus ----------------
    logic [UOP_W-1:0] pay [4];
    logic [3:0]       rv;
    logic             rp;
    logic             acc_now;
    int               u;
    int               rtok;

    initial begin
        // reset
        rst = 1'b0;
        idle(2);
        cmp_en = 1'b1;
        rst = 1'b1;
        idle(1);
        chk("rst_out0_valid", bus.out_uop0_valid, 1'b0);
        chk("rst_out1_valid", bus.out_uop1_valid, 1'b0);
        chk("rst_pause_req", bus.pause_req, 1'b0);

        // single-issue ordering
        drive(4'b0101, 128'hA, 128'h0, 128'hB, 128'h0, 1'b0, 1'b0);
        chk("si_out0", bus.out_uop0, 128'hA);
        chk("si_out1", bus.out_uop1, 128'hB);
        chk("si_count", dut.count, 0);
        drive(4'b1000, 128'h0, 128'h0, 128'h0, 128'hC, 1'b0, 1'b0);
        chk("si_c_out0", bus.out_uop0, 128'hC);
        chk("si_c_out1_valid", bus.out_uop1_valid, 1'b0);
        chk("si_c_out1_zero", bus.out_uop1, 128'h0);
        idle(1);
        chk("si_empty", bus.out_uop0_valid, 1'b0);

        // overflow: four uops per cycle; upstream advances only when accepted
        u = 0;
        for (int c = 0; c < 10; c++) begin
            acc_now = !bus.pause_req;
            drive(4'hF, tok(128'h1000, u), tok(128'h1000, u + 1), tok(128'h1000, u + 2),
                  tok(128'h1000, u + 3), 1'b0, 1'b0);
            if (acc_now) u += 4;
            if (c == 0) chk("ovf_c1_count", dut.count, 2);
            if (c == 2) begin
                chk("ovf_c3_pause_req", bus.pause_req, 1'b1);
                chk("ovf_c3_count", dut.count, 6);
                chk("ovf_c3_out0", bus.out_uop0, 128'h1004);
                chk("ovf_c3_out1", bus.out_uop1, 128'h1005);
            end
            if (c == 3) begin
                chk("ovf_c4_pause_req", bus.pause_req, 1'b0);
                chk("ovf_c4_out0", bus.out_uop0, 128'h1006);
                chk("ovf_c4_out1", bus.out_uop1, 128'h1007);
            end
        end
        idle(5);
        chk("ovf_drained_count", dut.count, 0);
        chk("ovf_drained_pause_req", bus.pause_req, 1'b0);

        // pause hold
        drive(4'b0011, 128'h2000, 128'h2001, '0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(4'b0011, tok(128'h2000, 2 + 2 * k), tok(128'h2000, 3 + 2 * k), '0, '0, 1'b1, 1'b0);
            chk("ph_out0_hold", bus.out_uop0, 128'h2000);
            chk("ph_out1_hold", bus.out_uop1, 128'h2001);
            chk("ph_count", dut.count, 2 * (k + 1));
        end
        chk("ph_pause_req", bus.pause_req, 1'b1);
        idle(1);
        chk("ph_drain1_out0", bus.out_uop0, 128'h2002);
        chk("ph_drain1_out1", bus.out_uop1, 128'h2003);
        idle(1);
        chk("ph_drain2_out0", bus.out_uop0, 128'h2004);
        idle(1);
        chk("ph_drain3_out1", bus.out_uop1, 128'h2007);
        idle(1);
        chk("ph_done", bus.out_uop0_valid, 1'b0);

        // flush wins over pause and over input acceptance
        drive(4'hF, 128'h3000, 128'h3001, 128'h3002, 128'h3003, 1'b0, 1'b0);
        drive(4'b0111, 128'h3004, 128'h3005, 128'h3006, '0, 1'b1, 1'b0);
        chk("fl_pre_count", dut.count, 5);
        chk("fl_pre_out0", bus.out_uop0, 128'h3000);
        chk("fl_pre_pause_req", bus.pause_req, 1'b1);
        drive(4'hF, 128'h3F00, 128'h3F01, 128'h3F02, 128'h3F03, 1'b1, 1'b1);
        chk("fl_count", dut.count, 0);
        chk("fl_out0_valid", bus.out_uop0_valid, 1'b0);
        chk("fl_out1_valid", bus.out_uop1_valid, 1'b0);
        chk("fl_pause_req", bus.pause_req, 1'b0);
        idle(3);
        chk("fl_after_out0_valid", bus.out_uop0_valid, 1'b0);

        // random valid patterns and pauses, many FIFO wraps
        rtok = 0;
        for (int c = 0; c < 250; c++) begin
            rv = 4'($urandom_range(0, 15));
            rp = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 4; i++) begin
                if (rv[i]) begin
                    pay[i] = tok(128'h4000, rtok);
                    rtok++;
                end else begin
                    pay[i] = tok(128'hBAD0, i);
                end
            end
            drive(rv, pay[0], pay[1], pay[2], pay[3], rp, 1'b0);
        end
        idle(6);
        chk("rand_drained_count", dut.count, 0);
        chk("rand_drained_out0_valid", bus.out_uop0_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
